// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_seq_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/div_seq_if.sv
// Start/busy/done handshake and operand/result bus between the arithmetic-unit
// controller (master) and the divider (slave).
interface div_seq_if #(
  parameter int width = div_seq_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [width-1:0] dividend;
  logic [width-1:0] divisor;
  logic             busy;
  logic             done;
  logic [width-1:0] quotient;
  logic [width-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_seq_sub_stage.sv
// Trial subtractor for one restoring step: a - b over width+1 bits, formed as
// a + ~b + 1 on a ripple chain of full-adder cells.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module sub_stage #(
  parameter int width = 6
) (
  input  logic [width:0]   a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] diff_o,
  output logic             borrow_o
);

  logic [width-1:0] b_inv_s;
  logic [width:0]   carry_s;

  assign b_inv_s    = ~b_i;
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < width; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_inv_s[i]),
      .c_i (carry_s[i]),
      .s_o (diff_o[i]),
      .c_o (carry_s[i+1])
    );
  end

  // Top bit of the zero-extended divisor inverts to 1; its sum is the sign of the difference.
  assign borrow_o = a_i[width] ^ 1'b1 ^ carry_s[width];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider: one shift/trial-subtract step per
// clock, start/busy/done handshake, results held until the next completion.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int               CNT_W    = $clog2(width);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(width - 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [width:0]   rsh_q, rsh_d;
  logic [width-1:0] q_q, q_d;
  logic [width-1:0] dsr_q, dsr_d;
  logic [width-1:0] quot_q, quot_d;
  logic [width-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [width-1:0] diff_s;
  logic             borrow_s;
  logic [width-1:0] r_new_s;
  logic [width-1:0] q_new_s;
  logic             dvs_zero_s;

  // rsh_q holds the partial remainder already shifted left with the next
  // dividend bit appended, so it feeds the trial subtractor directly.
  sub_stage #(.width(width)) u_sub (
    .a_i      (rsh_q),
    .b_i      (dsr_q),
    .diff_o   (diff_s),
    .borrow_o (borrow_s)
  );

  assign dvs_zero_s = (bus.divisor == {width{1'b0}});
  assign r_new_s    = borrow_s ? rsh_q[width-1:0] : diff_s;
  assign q_new_s    = {q_q[width-2:0], ~borrow_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = dvs_zero_s ? ST_FIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsh_q  <= {(width+1){1'b0}};
      q_q    <= {width{1'b0}};
      dsr_q  <= {width{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      quot_q <= {width{1'b0}};
      rem_q  <= {width{1'b0}};
      dbz_q  <= 1'b0;
    end else begin
      rsh_q  <= rsh_d;
      q_q    <= q_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  always_comb begin
    rsh_d  = rsh_q;
    q_d    = q_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (dvs_zero_s) begin
            quot_d = {width{1'b1}};
            rem_d  = bus.dividend;
            dbz_d  = 1'b1;
          end else begin
            // Dividend MSB moves into the remainder now; Q keeps the remaining bits.
            rsh_d = {{width{1'b0}}, bus.dividend[width-1]};
            q_d   = {bus.dividend[width-2:0], 1'b0};
            dsr_d = bus.divisor;
            cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        rsh_d = {r_new_s, q_q[width-1]};
        q_d   = q_new_s;
        if (cnt_q == LAST_CNT) begin
          quot_d = q_new_s;
          rem_d  = r_new_s;
          dbz_d  = 1'b0;
          cnt_d  = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes reference results computed with
// plain / and %, a negedge monitor pops and compares when done is due.
module tb_div_seq;

  localparam int W    = 6;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_if #(.width(W)) bus ();

  div_seq #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int z;
    int done_edge;
  } exp_t;

  exp_t sb[$];
  int   edge_n      = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   act_start   = -1;
  int   act_end     = -1;
  int   held_q      = 0;
  int   held_r      = 0;
  int   held_z      = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference: ordinary integer division; divide-by-zero returns all ones and the dividend.
  function automatic exp_t model(input int dvd, input int dvs, input int t);
    exp_t e;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 0) begin
      e.q = MAXV; e.r = dvd; e.z = 1; e.done_edge = t;
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.z = 0; e.done_edge = t + W;
    end
    return e;
  endfunction

  // Monitor: done must appear exactly when the oldest expectation is due.
  initial begin
    exp_t cur;
    logic exp_done;
    forever begin
      @(negedge clk);
      exp_done = (sb.size() > 0) && (sb[0].done_edge == edge_n);
      chk("done", bus.done, exp_done);
      if (exp_done) begin
        cur    = sb.pop_front();
        held_q = cur.q;
        held_r = cur.r;
        held_z = cur.z;
        if (cur.z == 0) begin
          chk("invariant", int'(bus.quotient) * cur.dvs + int'(bus.remainder), cur.dvd);
          chk("rem_lt_divisor", int'(bus.remainder) < cur.dvs, 1);
        end
      end
      chk("busy", bus.busy, (edge_n >= act_start) && (edge_n <= act_end));
      chk("quotient", bus.quotient, held_q);
      chk("remainder", bus.remainder, held_r);
      chk("div_by_zero", bus.div_by_zero, held_z);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int dvd, input int dvs, output int t);
    exp_t e;
    int   n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", n < 64, 1);
    bus.start    = 1'b1;
    bus.dividend = W'(dvd);
    bus.divisor  = W'(dvs);
    @(posedge clk);
    #1;
    t            = edge_n;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    e            = model(dvd, dvs, t);
    sb.push_back(e);
    act_start    = t;
    act_end      = e.done_edge;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int dvd, input int dvs);
    bus.start    = 1'b1;
    bus.dividend = W'(dvd);
    bus.divisor  = W'(dvs);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int n;
    int off;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(45, 7, t);
    issue(63, 1, t);
    repeat (4) @(negedge clk);
    issue(5, 9, t);
    repeat (4) @(negedge clk);
    issue(17, 0, t);
    repeat (3) @(negedge clk);

    // Starts during RUN and during FIN must both be dropped.
    issue(40, 6, t);
    repeat (2) @(negedge clk);
    pulse_start(9, 3);
    n = 0;
    while (edge_n != t + W && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_fin", edge_n, t + W);
    pulse_start(9, 3);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a division.
    issue(50, 5, t);
    repeat (3) @(posedge clk);
    #2;
    rst       = 1'b1;
    sb.delete();
    act_end   = -1;
    held_q    = 0;
    held_r    = 0;
    held_z    = 0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(50, 5, t);

    off = $urandom_range(0, MAXV);
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 1; b <= MAXV; b++) begin
        issue((a + off) % (MAXV + 1), b, t);
      end
    end

    repeat (150) issue($urandom_range(0, MAXV), $urandom_range(0, MAXV), t);

    n = 0;
    while (sb.size() > 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
